// File: rtl/audio_pkg.sv
// audio_pkg: shared audio sample type, I2S frame geometry and slot helpers
// used by the I2S codec master and its bit timer.
package audio_pkg;

   typedef logic signed [15:0] audio_t;

   // A frame is 64 BCLK periods: 32 slots per channel.
   localparam int I2S_SLOTS = 32;
   localparam int I2S_FRAME = 64;

   localparam int SLOT_W = $clog2(I2S_FRAME);
   localparam int IDX_W  = $clog2(I2S_SLOTS);

   // Frame-wide slot counter value; bit 5 selects the channel (1 = right).
   typedef logic [SLOT_W-1:0] slot_t;

   // True when the slot carries a data bit of a ws-bit word. Standard I2S
   // mode: slot 0 of each channel is the one-bit delay, the MSB sits in
   // slot 1 and the LSB in slot ws.
   function automatic logic is_data_slot(input slot_t slot, input int ws);
      logic [IDX_W-1:0] idx;
      idx = slot[IDX_W-1:0];
      return (idx != '0) && (int'(idx) <= ws);
   endfunction

endpackage

// File: rtl/i2s_codec_master_if.sv
// i2s_codec_master_if: BCLK/LRCK timing bundle. The bit timer drives it,
// the serializer/deserializer in the codec master consumes it.
interface i2s_codec_master_if;
   import audio_pkg::*;

   logic  bclk;         // bit clock level
   logic  lrck;         // frame clock level, 1 = right channel
   logic  rise;         // this clock edge raises bclk
   logic  fall;         // this clock edge lowers bclk and advances the slot
   logic  frame_start;  // this fall wraps the slot counter to 0
   slot_t slot;         // current slot counter
   slot_t next_slot;    // slot counter after the next fall

   modport timer (output bclk, lrck, rise, fall, frame_start, slot, next_slot);
   modport core  (input  bclk, lrck, rise, fall, frame_start, slot, next_slot);

endinterface

// File: rtl/i2s_bit_timer.sv
// i2s_bit_timer: divides the system clock into BCLK, keeps the 64-slot frame
// counter and publishes rise/fall/frame-start strobes for the current edge.
module i2s_bit_timer
   import audio_pkg::*;
#(
   parameter int BCLK_DIV = 16
)
(
   input  logic              iCLK_50,
   input  logic              iRST_N,
   i2s_codec_master_if.timer tmr
);

   logic [7:0] div_cnt;
   logic       bclk_q;
   slot_t      slot_q;
   logic       terminal;

   assign terminal = (div_cnt == 8'(BCLK_DIV - 1));

   // Divider wraps at terminal count and toggles BCLK; every BCLK fall
   // advances the slot counter. Reset parks the counter at 63 so the first
   // fall after release is a frame start.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of the order of statements or blocks.
   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         div_cnt <= '0;
         bclk_q  <= 1'b0;
         slot_q  <= '1;
      end else if (terminal) begin
         div_cnt <= '0;
         bclk_q  <= ~bclk_q;
         if (bclk_q) begin
            slot_q <= slot_q + slot_t'(1);
         end
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   // LRCK is the registered top bit of the slot counter, so it moves on the
   // fall event together with the slot.
   assign tmr.bclk        = bclk_q;
   assign tmr.lrck        = slot_q[SLOT_W-1];
   assign tmr.slot        = slot_q;
   assign tmr.next_slot   = slot_q + slot_t'(1);
   assign tmr.rise        = terminal & ~bclk_q;
   assign tmr.fall        = terminal & bclk_q;
   assign tmr.frame_start = terminal & bclk_q & (slot_q == '1);

endmodule

// File: rtl/i2s_codec_master.sv
// i2s_codec_master: I2S standard-mode master. Serializes held stereo samples
// onto oADCDAT, deserializes iDACDAT into oL/oR, and runs a one-deep
// valid/ready holding register in front of the transmit shifter.
module i2s_codec_master
   import audio_pkg::*;
#(
   parameter int BCLK_DIV = 16,
   parameter int WS       = 16
)
(
   input  logic                 iCLK_50,
   input  logic                 iRST_N,
   input  logic signed [WS-1:0] iL,
   input  logic signed [WS-1:0] iR,
   input  logic                 iValid,
   output logic                 oReady,
   output logic                 oBCLK,
   output logic                 oLRCK,
   output logic                 oADCDAT,
   input  logic                 iDACDAT,
   output logic signed [WS-1:0] oL,
   output logic signed [WS-1:0] oR,
   output logic                 oValid,
   output logic                 oUnderrun
);

   localparam int FW = 2 * WS;   // {left, right} frame word

   i2s_codec_master_if tmr_if ();

   i2s_bit_timer #(
      .BCLK_DIV (BCLK_DIV)
   ) u_timer (
      .iCLK_50 (iCLK_50),
      .iRST_N  (iRST_N),
      .tmr     (tmr_if)
   );

   assign oBCLK = tmr_if.bclk;
   assign oLRCK = tmr_if.lrck;

   logic [FW-1:0] hold_q;   // accepted sample waiting for the next frame
   logic [FW-1:0] tx_sh;    // frame being transmitted, MSB goes out next
   logic [FW-1:0] rx_sh;    // frame being received, shifted in MSB first
   logic          rx_last;  // rise of right-channel slot WS: frame complete
   logic          rx_done;  // rx_sh holds a complete frame this cycle
   logic          tx_slot;  // slot entered on this fall carries data
   logic          rx_slot;  // current slot carries data
   logic          accept;

   assign accept  = iValid & oReady;
   assign tx_slot = is_data_slot(tmr_if.next_slot, WS);
   assign rx_slot = is_data_slot(tmr_if.slot, WS);
   assign rx_last = tmr_if.rise & tmr_if.slot[SLOT_W-1]
                    & (tmr_if.slot[IDX_W-1:0] == IDX_W'(WS));

   // Holding register handshake: a frame start drains a full register;
   // otherwise a transfer fills it. A transfer on the frame start of an
   // empty register is still accepted but only serves the following frame.
   // NOTE: the holding data is reset along with its flag so a reset can
   // never leak a stale sample into a later frame.
   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         hold_q    <= '0;
         oReady    <= 1'b1;
         oUnderrun <= 1'b0;
      end else begin
         oUnderrun <= tmr_if.frame_start & oReady;
         if (tmr_if.frame_start && !oReady) begin
            oReady <= 1'b1;
         end else if (accept) begin
            hold_q <= {iL, iR};
            oReady <= 1'b0;
         end
      end
   end

   // Transmit: load the frame word (or silence) at frame start, then emit one
   // bit per data slot on the BCLK fall; non-data slots drive 0.
   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         tx_sh   <= '0;
         oADCDAT <= 1'b0;
      end else begin
         if (tmr_if.frame_start) begin
            tx_sh <= oReady ? '0 : hold_q;
         end else if (tmr_if.fall && tx_slot) begin
            tx_sh <= {tx_sh[FW-2:0], 1'b0};
         end
         if (tmr_if.fall) begin
            oADCDAT <= tx_slot & tx_sh[FW-1];
         end
      end
   end

   // Receive: sample iDACDAT on BCLK rise in data slots; one clock after the
   // last right-channel bit, publish the pair and pulse oValid.
   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         rx_sh   <= '0;
         rx_done <= 1'b0;
         oL      <= '0;
         oR      <= '0;
         oValid  <= 1'b0;
      end else begin
         if (tmr_if.rise && rx_slot) begin
            rx_sh <= {rx_sh[FW-2:0], iDACDAT};
         end
         rx_done <= rx_last;
         oValid  <= rx_done;
         if (rx_done) begin
            oL <= rx_sh[FW-1:WS];
            oR <= rx_sh[WS-1:0];
         end
      end
   end

endmodule
